// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
// Adds two W-bit operands (W = 4*NIBBLES) plus a carry-in with one shared
// 4-bit ripple-carry adder, one nibble per cycle, least significant nibble first.
// A valid/ready handshake accepts the request and another one returns the result.
// Optional feature macro NIBBLE_SERIAL_ADDER_SUB_EN adds a 'sub' input that
// selects a - b instead of a + b + cin.
//
// state | meaning
// IDLE  | waiting for a request, in_ready = 1
// RUN   | one nibble added per cycle, idx selects the nibble
// DONE  | result held on sum/cout/ovf until out_ready
module nibble_serial_adder_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   input  logic                   cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
   input  logic                   sub,
`endif
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*NIBBLES-1:0]   sum,
   output logic                   cout,
   output logic                   ovf
);

   localparam int W    = 4 * NIBBLES;
   localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]      state;
   logic [IDXW-1:0] idx;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic            carry_q;
   logic [W-1:0]    sum_q;
   logic            cout_q;
   logic            ovf_q;

   logic [3:0]      na;
   logic [3:0]      nb;
   logic [3:0]      ns;
   logic [4:0]      c;
   logic            last;
   logic            sub_sel;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
   assign sub_sel = sub;
`else
   assign sub_sel = 1'b0;
`endif

   assign last = (idx == IDXW'(NIBBLES - 1));

   // Shared 4-bit ripple-carry adder on the currently selected nibble.
   always_comb begin
      na   = a_q[{idx, 2'b00} +: 4];
      nb   = b_q[{idx, 2'b00} +: 4];
      ns   = 4'd0;
      c    = 5'd0;
      c[0] = carry_q;
      for (int i = 0; i < 4; i++) begin
         ns[i]   = na[i] ^ nb[i] ^ c[i];
         c[i+1]  = (na[i] & nb[i]) | (na[i] & c[i]) | (nb[i] & c[i]);
      end
   end

   // Sequencer: accept, per-nibble accumulate, hold result until consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         idx     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  // Subtraction is a + ~b + 1; b is stored already inverted.
                  a_q     <= a;
                  b_q     <= sub_sel ? ~b : b;
                  carry_q <= sub_sel ? 1'b1 : cin;
                  sum_q   <= '0;
                  cout_q  <= 1'b0;
                  ovf_q   <= 1'b0;
                  idx     <= '0;
                  state   <= S_RUN;
               end
            end
            S_RUN: begin
               sum_q[{idx, 2'b00} +: 4] <= ns;
               carry_q                  <= c[4];
               if (last) begin
                  cout_q <= c[4];
                  ovf_q  <= c[3] ^ c[4];
                  idx    <= '0;
                  state  <= S_DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (state == S_IDLE) && !rst;
   assign out_valid = (state == S_DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl (NIBBLES = 4): directed vectors plus a
// random stream; expected results are queued on accept and popped by a monitor.
module tb_nibble_serial_adder_ctrl;

   localparam int NIB = 4;
   localparam int W   = 16;

   typedef struct packed {
      logic [W-1:0] s;
      logic         co;
      logic         ov;
   } res_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int   checks = 0;
   int   errors = 0;
   int   rcv    = 0;
   res_t exp_q[$];

   always #5 clk = ~clk;

   nibble_serial_adder_ctrl #(.NIBBLES(NIB)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic c, input logic s);
      logic [W-1:0] yy;
      logic         ci;
      logic [W:0]   t;
      res_t         r;
      yy   = s ? ~y : y;
      ci   = s ? 1'b1 : c;
      t    = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, ci};
      r.s  = t[W-1:0];
      r.co = t[W];
      r.ov = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
      return r;
   endfunction

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (!rst && out_valid) begin
            chk("in_ready_low_in_done", {31'b0, in_ready}, 32'd0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result actual=%h required=none", sum);
            end else begin
               chk("result", {14'b0, sum, cout, ovf}, {14'b0, exp_q[0]});
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  rcv++;
               end
            end
         end
      end
   endtask

   task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic vc, input logic vs, input res_t e);
      logic acc;
      acc = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a   = va;
      b   = vb;
      cin = vc;
      sub = vs;
      for (int n = 0; n < 50 && !acc; n++) begin
         @(negedge clk);
         acc = in_ready;
      end
      chk("accept", {31'b0, acc}, 32'd1);
      if (acc) exp_q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a   = 16'($urandom());
      b   = 16'($urandom());
      cin = ~vc;
      sub = ~vs;
   endtask

   // Returns the cycle index (accept cycle = 0) in which out_valid is first seen.
   task automatic wait_valid(output int k);
      k = 0;
      for (int n = 1; n <= 30 && k == 0; n++) begin
         @(negedge clk);
         if (out_valid) k = n;
      end
   endtask

   initial begin
      int   k;
      int   issued;
      int   rcv_base;
      logic acc;
      logic use_sub;

      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b0;
      fork
         monitor();
      join_none

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready",  {31'b0, in_ready},  32'd0);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_sum",       {16'b0, sum},       32'd0);
      chk("rst_cout",      {31'b0, cout},      32'd0);
      chk("rst_ovf",       {31'b0, ovf},       32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("in_ready_after_rst", {31'b0, in_ready}, 32'd1);

      // FFFF + 0001: full carry ripple, fixed latency, ready right after handshake
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(16'hFFFF, 16'h0001, 1'b0, 1'b0, '{s: 16'h0000, co: 1'b1, ov: 1'b0});
      wait_valid(k);
      chk("latency", k, 32'd5);
      @(negedge clk);
      chk("in_ready_after_hs", {31'b0, in_ready}, 32'd1);

      // 7FFF + 0 + cin: signed overflow into the sign bit
      send(16'h7FFF, 16'h0000, 1'b1, 1'b0, '{s: 16'h8000, co: 1'b0, ov: 1'b1});
      wait_valid(k);
      chk("latency2", k, 32'd5);

      // Result held under back-pressure while inputs wander
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      send(16'h1234, 16'h4321, 1'b0, 1'b0, '{s: 16'h5555, co: 1'b0, ov: 1'b0});
      wait_valid(k);
      chk("latency3", k, 32'd5);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         a = 16'($urandom());
         b = 16'($urandom());
         @(negedge clk);
         chk("hold_valid", {31'b0, out_valid}, 32'd1);
         chk("hold_sum",   {16'b0, sum},       32'h5555);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("idle_after_hold", {31'b0, in_ready}, 32'd1);

      // Reset in the second RUN cycle discards the operation
      send(16'h1111, 16'h2222, 1'b0, 1'b0, '{s: 16'h3333, co: 1'b0, ov: 1'b0});
      @(negedge clk);
      chk("run_sum_cleared", {16'b0, sum}, 32'h0000);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("run_partial", {16'b0, sum}, 32'h0003);
      @(negedge clk);
      chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
      chk("abort_sum",       {16'b0, sum},       32'd0);
      chk("abort_cout",      {31'b0, cout},      32'd0);
      chk("abort_in_ready",  {31'b0, in_ready},  32'd0);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("in_ready_after_abort", {31'b0, in_ready}, 32'd1);
      send(16'h0003, 16'h0004, 1'b0, 1'b0, '{s: 16'h0007, co: 1'b0, ov: 1'b0});
      wait_valid(k);
      chk("latency4", k, 32'd5);

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
      send(16'h0005, 16'h0007, 1'b0, 1'b1, '{s: 16'hFFFE, co: 1'b0, ov: 1'b0});
      wait_valid(k);
      send(16'h8000, 16'h0001, 1'b0, 1'b1, '{s: 16'h7FFF, co: 1'b1, ov: 1'b1});
      wait_valid(k);
      send(16'h0005, 16'h0007, 1'b1, 1'b1, '{s: 16'hFFFE, co: 1'b0, ov: 1'b0});
      wait_valid(k);
`endif
      @(negedge clk);

      // Random stream with gaps on both sides
      issued   = 0;
      rcv_base = rcv;
      acc      = 1'b0;
      for (int cyc = 0; cyc < 5000 && !(issued == 100 && exp_q.size() == 0); cyc++) begin
         @(negedge clk);
         acc = in_valid && in_ready;
         if (acc) begin
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
            use_sub = sub;
`else
            use_sub = 1'b0;
`endif
            exp_q.push_back(model(a, b, cin, use_sub));
            issued++;
         end
         @(posedge clk);
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
         if (acc || !in_valid) begin
            if (issued < 100 && $urandom_range(0, 2) != 0) begin
               in_valid = 1'b1;
               a   = 16'($urandom());
               b   = 16'($urandom());
               cin = 1'($urandom_range(0, 1));
               sub = 1'($urandom_range(0, 1));
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      in_valid = 1'b0;
      chk("random_issued",   issued,          32'd100);
      chk("random_received", rcv - rcv_base,  32'd100);
      chk("queue_empty",     exp_q.size(),    32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
NIBBLE_SERIAL_ADDER_CTRL -- requirements
Module: nibble_serial_adder_ctrl

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the operand width in 4-bit nibbles (W = 4*NIBBLES); legal range 1..16.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1, the operand request is valid.
REQ-005 The block SHALL have port in_ready, output, 1, the block accepts a request this cycle.
REQ-006 The block SHALL have ports a and b, input, W each, the operands.
REQ-007 The block SHALL have port cin, input, 1, the carry-in of the whole operation.
REQ-008 The block SHALL have port out_valid, output, 1, the result is valid.
REQ-009 The block SHALL have port out_ready, input, 1, the consumer accepts the result.
REQ-010 The block SHALL have port sum, output, W, the result word.
REQ-011 The block SHALL have ports cout and ovf, output, 1 each: the final carry-out and the signed overflow.

Function
REQ-012 The block SHALL compute {cout,sum} = a + b + cin with one shared 4-bit ripple-carry adder of four full adders, used once per cycle, least significant nibble first.
REQ-013 The block SHALL implement the states IDLE, RUN and DONE.
REQ-014 In IDLE, in_ready SHALL be 1; in RUN and DONE it SHALL be 0.
REQ-015 When in_valid and in_ready are both 1, the block SHALL latch a, b and cin into internal registers, clear the nibble index to 0 and enter RUN.
REQ-016 In each RUN cycle, the block SHALL add nibble[idx] of the latched a and b plus the carry register.
  - Write the 4-bit result into sum nibble idx.
  - Load the adder carry-out into the carry register.
  - Increment idx.
REQ-017 After the RUN cycle with idx = NIBBLES-1, the block SHALL enter DONE.
  - out_valid = 1.
  - cout = the final carry.
  - ovf = carry into the MSB XOR the carry out of the MSB.
REQ-018 Latency SHALL be fixed: out_valid asserts exactly NIBBLES+1 cycles after the accepting edge.
REQ-019 In DONE, sum, cout and ovf SHALL hold stable until out_valid and out_ready are both 1.
  - Then the block returns to IDLE.
  - in_ready is 1 in the following cycle.
REQ-020 Input changes while in RUN or DONE SHALL have no effect on the result in flight.
REQ-021 out_ready outside DONE SHALL be ignored.
REQ-022 Minimum initiation interval SHALL be NIBBLES+2 cycles; accept and result handshakes never occur in the same cycle.
REQ-023 sum nibbles not yet computed SHALL read 0 during RUN, because sum is cleared on accept.

Reset
REQ-024 With rst = 1 at a clock edge, the block SHALL enter IDLE from any state, including mid-RUN and DONE, and discard the operation in flight.
  - idx = 0, carry register = 0.
  - sum = 0, cout = 0, ovf = 0.
  - out_valid = 0.
REQ-025 During reset, in_ready SHALL be 0; it SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-026 Macro NIBBLE_SERIAL_ADDER_SUB_EN, when defined, SHALL add input port sub (1 bit, latched on accept).
  - When sub = 1, the block computes a - b: it inverts b's nibbles into the adder and forces the initial carry to 1, ignoring cin.
  - cout = 1 means no borrow.
  - ovf follows REQ-017.
REQ-027 When NIBBLE_SERIAL_ADDER_SUB_EN is undefined, the port sub SHALL be absent and the block SHALL add only.

Verification (NIBBLES = 4)
REQ-028 Reset release, then a=16'hFFFF, b=16'h0001, cin=0 with out_ready=1 -> out_valid exactly 5 cycles after accept, with sum=16'h0000, cout=1, ovf=0; in_ready=1 one cycle later.
REQ-029 a=16'h7FFF, b=16'h0000, cin=1 -> sum=16'h8000, cout=0, ovf=1.
REQ-030 a=16'h1234, b=16'h4321, cin=0, out_ready held 0 for 3 cycles after out_valid -> sum=16'h5555 stable throughout, in_ready=0, a/b changed meanwhile with no effect, IDLE after the handshake.
REQ-031 rst asserted on the second RUN cycle -> next cycle out_valid=0, sum=0, cout=0; in_ready=1 the cycle after rst drops; a fresh 16'h0003+16'h0004 gives 16'h0007.
REQ-032 With NIBBLE_SERIAL_ADDER_SUB_EN: sub=1, a=16'h0005, b=16'h0007, cin=0 -> sum=16'hFFFE, cout=0, ovf=0; a=16'h8000, b=16'h0001 -> sum=16'h7FFF, cout=1, ovf=1.
REQ-033 Back-to-back stream of 100 random operand pairs with random in_valid/out_ready gaps -> every result equals the reference model, in order, with no request dropped or duplicated.
